// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_REQ0,
    GNT_REQ1
  } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus between the writeback sources / decode stage and the arbiter.
// master = requesters and decode; slave = rf_wb_arbiter.
interface rf_wb_arbiter_if;
  import rf_arb_pkg::*;

  logic      req0_valid;
  reg_addr_t req0_addr;
  word_t     req0_data;
  logic      req0_ready;

  logic      req1_valid;
  reg_addr_t req1_addr;
  word_t     req1_data;
  logic      req1_ready;

  logic      resv_valid;
  reg_addr_t resv_addr;
  logic      resv_ready;

  reg_addr_t rd_addr1;
  reg_addr_t rd_addr2;
  logic      hazard1;
  logic      hazard2;

  logic      rf_we;
  reg_addr_t rf_addr;
  word_t     rf_wdata;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output resv_valid, resv_addr,
    output rd_addr1, rd_addr2,
    input  req0_ready, req1_ready, resv_ready,
    input  hazard1, hazard2,
    input  rf_we, rf_addr, rf_wdata
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  resv_valid, resv_addr,
    input  rd_addr1, rd_addr2,
    output req0_ready, req1_ready, resv_ready,
    output hazard1, hazard2,
    output rf_we, rf_addr, rf_wdata
  );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Scoreboard of registers reserved by the multi-cycle unit, plus the
// decode-stage read-hazard lookups. Register x0 is never reserved.
module rf_scoreboard
  import rf_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_valid,
  input  reg_addr_t set_addr,
  output logic      set_ready,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  logic      pend_we,
  input  reg_addr_t pend_addr,
  input  reg_addr_t rd_addr1,
  input  reg_addr_t rd_addr2,
  output logic      hazard1,
  output logic      hazard2
);

  logic [NREGS-1:0] sb_reg;
  logic [NREGS-1:0] sb_next;
  reg_addr_t        rd_addr [2];
  logic [1:0]       hazard;

  // A reservation is accepted when the register is free or is being released this cycle.
  always_comb begin
    set_ready = !sb_reg[set_addr] || (clr_en && (clr_addr == set_addr)) || (set_addr == '0);
  end

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    sb_next = sb_reg;
    if (clr_en) begin
      sb_next[clr_addr] = 1'b0;
    end
    if (set_valid && set_ready && (set_addr != '0)) begin
      sb_next[set_addr] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_reg <= '0;
    end else begin
      sb_reg <= sb_next;
    end
  end

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;

  // A read stalls on a reserved register or on a write still sitting in the output register.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_hazard
    assign hazard[gi] = (rd_addr[gi] != '0) &&
                        (sb_reg[rd_addr[gi]] || (pend_we && (pend_addr == rd_addr[gi])));
  end

  assign hazard1 = hazard[0];
  assign hazard2 = hazard[1];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: shares one write port between the core
// writeback (requester 0) and a multi-cycle unit (requester 1).
// Optional macro RF_ARB_RR_EN: round-robin on conflicts; otherwise
// requester 0 always wins and no last_grant register exists.
module rf_wb_arbiter
  import rf_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  grant_e    gnt;
  logic      hs;
  logic      hs1;
  reg_addr_t hs_addr;
  word_t     hs_data;

  logic      rf_we_reg;
  reg_addr_t rf_addr_reg;
  word_t     rf_wdata_reg;

`ifdef RF_ARB_RR_EN
  // 1 means requester 1 was granted most recently.
  logic last_grant_reg;
`endif

  // Pick at most one winner; nobody is granted during reset.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef RF_ARB_RR_EN
        gnt = last_grant_reg ? GNT_REQ0 : GNT_REQ1;
`else
        gnt = GNT_REQ0;
`endif
      end else if (bus.req0_valid) begin
        gnt = GNT_REQ0;
      end else if (bus.req1_valid) begin
        gnt = GNT_REQ1;
      end
    end
  end

  assign bus.req0_ready = (gnt == GNT_REQ0);
  assign bus.req1_ready = (gnt == GNT_REQ1);
  assign hs             = (gnt != GNT_NONE);
  assign hs1            = (gnt == GNT_REQ1);
  assign hs_addr        = hs1 ? bus.req1_addr : bus.req0_addr;
  assign hs_data        = hs1 ? bus.req1_data : bus.req0_data;

`ifdef RF_ARB_RR_EN
  // Round-robin pointer moves only on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (hs) begin
      last_grant_reg <= hs1;
    end
  end
`endif

  // Output register toward WE3/A3/WD3; x0 writes complete but never assert WE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg    <= 1'b0;
      rf_addr_reg  <= '0;
      rf_wdata_reg <= '0;
    end else if (hs) begin
      rf_we_reg    <= (hs_addr != '0);
      rf_addr_reg  <= hs_addr;
      rf_wdata_reg <= hs_data;
    end else begin
      rf_we_reg    <= 1'b0;
    end
  end

  assign bus.rf_we    = rf_we_reg;
  assign bus.rf_addr  = rf_addr_reg;
  assign bus.rf_wdata = rf_wdata_reg;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (bus.resv_valid),
    .set_addr  (bus.resv_addr),
    .set_ready (bus.resv_ready),
    .clr_en    (hs1),
    .clr_addr  (bus.req1_addr),
    .pend_we   (rf_we_reg),
    .pend_addr (rf_addr_reg),
    .rd_addr1  (bus.rd_addr1),
    .rd_addr2  (bus.rd_addr2),
    .hazard1   (bus.hazard1),
    .hazard2   (bus.hazard2)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the write port and reservation table.
module tb_rf_wb_arbiter;
  import rf_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit          m_sb [32];
  int          m_last;      // requester granted most recently
  bit          m_we;
  int          m_addr;
  logic [31:0] m_data;
  // Model results for the current cycle, applied at the next edge
  bit          n_hs0, n_hs1;
  bit          n_sb [32];
  int          n_last;
  bit          n_we;
  int          n_addr;
  logic [31:0] n_data;
  bit          n_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_sb[i]) m_sb[i] = 1'b0;
    m_last = 1;
    m_we   = 1'b0;
    m_addr = 0;
    m_data = '0;
  endtask

  // Let inputs settle, compare every output with the model, prepare next state.
  task automatic eval();
    bit v0, v1, r0, r1, rr, h1, h2;
    int a0, a1, ra, d1, d2;
    #2;
    v0 = bus.req0_valid;  v1 = bus.req1_valid;
    a0 = int'(bus.req0_addr); a1 = int'(bus.req1_addr);
    ra = int'(bus.resv_addr);
    d1 = int'(bus.rd_addr1); d2 = int'(bus.rd_addr2);
    r0 = 1'b0; r1 = 1'b0;
    if (!rst) begin
      if (v0 && v1) begin
`ifdef RF_ARB_RR_EN
        if (m_last == 0) r1 = 1'b1; else r0 = 1'b1;
`else
        r0 = 1'b1;
`endif
      end else begin
        r0 = v0;
        r1 = v1;
      end
    end
    rr = !m_sb[ra] || (r1 && a1 == ra) || (ra == 0);
    h1 = (d1 != 0) && (m_sb[d1] || (m_we && m_addr == d1));
    h2 = (d2 != 0) && (m_sb[d2] || (m_we && m_addr == d2));

    chk("req0_ready", bus.req0_ready, r0);
    chk("req1_ready", bus.req1_ready, r1);
    chk("resv_ready", bus.resv_ready, rr);
    chk("hazard1",    bus.hazard1,    h1);
    chk("hazard2",    bus.hazard2,    h2);
    chk("rf_we",      bus.rf_we,      m_we);
    chk("rf_addr",    bus.rf_addr,    m_addr);
    chk("rf_wdata",   bus.rf_wdata,   m_data);

    n_rst = rst;
    n_hs0 = r0;
    n_hs1 = r1;
    n_sb  = m_sb;
    n_last = m_last;
    n_we  = 1'b0;
    n_addr = m_addr;
    n_data = m_data;
    if (r0 || r1) begin
      n_addr = r1 ? a1 : a0;
      n_data = r1 ? bus.req1_data : bus.req0_data;
      n_we   = (n_addr != 0);
      n_last = r1 ? 1 : 0;
      $display("WR req%0d x%0d = %08h", r1 ? 1 : 0, n_addr, n_data);
    end
    if (r1) n_sb[a1] = 1'b0;
    if (bus.resv_valid && rr && ra != 0) n_sb[ra] = 1'b1;
  endtask

  // Advance one clock edge and commit the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (n_rst) begin
      model_reset();
    end else begin
      m_sb   = n_sb;
      m_last = n_last;
      m_we   = n_we;
      m_addr = n_addr;
      m_data = n_data;
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.resv_valid = 1'b0; bus.resv_addr = '0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
  endtask

  initial begin
    int exp_g [4];
    int g;
    bit p0, p1;
    int a0, a1;
    logic [31:0] d0, d1;

    idle_inputs();
    model_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd2;
    bus.rd_addr1 = 5'd1;   bus.rd_addr2 = 5'd2;
    @(posedge clk); #1;

    // Reset held 3 cycles with both requests pending
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_rf_we",  bus.rf_we, 0);
      chk("rst_hazard1", bus.hazard1, 0);
      chk("rst_resv_ready", bus.resv_ready, 1);
      tick();
    end
    rst = 1'b0;

    // Contention: both continuously valid for 4 cycles
`ifdef RF_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      bus.req0_data = $urandom;
      bus.req1_data = $urandom;
      eval();
      g = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : -1);
      chk("cont_grant", g, exp_g[i]);
      tick();
    end
    idle_inputs();

    // Single write to x5
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEADBEEF;
    bus.rd_addr1 = 5'd5;
    eval();
    chk("sw_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    eval();
    chk("sw_rf_we", bus.rf_we, 1);
    chk("sw_rf_addr", bus.rf_addr, 5);
    chk("sw_rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("sw_hazard_hi", bus.hazard1, 1);
    tick();
    eval();
    chk("sw_hazard_lo", bus.hazard1, 0);
    tick();

    // x0 write and x0 reservation
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd0; bus.req0_data = 32'hFFFFFFFF;
    eval();
    chk("x0_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.resv_valid = 1'b1; bus.resv_addr = 5'd0;
    bus.rd_addr1 = 5'd0;
    eval();
    chk("x0_rf_we", bus.rf_we, 0);
    chk("x0_resv_ready", bus.resv_ready, 1);
    tick();
    bus.resv_valid = 1'b0;
    eval();
    chk("x0_hazard", bus.hazard1, 0);
    tick();

    // Scoreboard: reserve x7, double reservation, release, re-reserve on release
    bus.resv_valid = 1'b1; bus.resv_addr = 5'd7; bus.rd_addr2 = 5'd7;
    eval();
    chk("sb_resv1", bus.resv_ready, 1);
    tick();
    eval();
    chk("sb_resv2_blocked", bus.resv_ready, 0);
    chk("sb_hazard_set", bus.hazard2, 1);
    tick();
    bus.resv_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'h12;
    eval();
    chk("sb_ready1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    eval();
    chk("sb_hazard_k1", bus.hazard2, 1);
    chk("sb_rf_wdata", bus.rf_wdata, 32'h12);
    tick();
    eval();
    chk("sb_hazard_k2", bus.hazard2, 0);
    tick();
    bus.resv_valid = 1'b1; bus.resv_addr = 5'd7;
    eval();
    tick();
    bus.req1_valid = 1'b1; bus.req1_data = 32'h34;
    eval();
    chk("sb_rereserve_ready", bus.resv_ready, 1);
    tick();
    bus.req1_valid = 1'b0; bus.resv_valid = 1'b0;
    eval();
    tick();
    eval();
    chk("sb_stays_set", bus.hazard2, 1);
    tick();

    // Mid-operation reset right after a handshake
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA5A5_0003;
    bus.rd_addr1 = 5'd3;
    eval();
    tick();
    rst = 1'b1;
    eval();
    chk("mr_pending_we", bus.rf_we, 1);
    chk("mr_ready0_in_rst", bus.req0_ready, 0);
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    eval();
    chk("mr_we_cancel", bus.rf_we, 0);
    chk("mr_sb_cleared", bus.hazard2, 0);
    tick();

    // Randomized traffic
    p0 = 1'b0; p1 = 1'b0;
    a0 = 0; a1 = 0; d0 = '0; d1 = '0;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin
        p0 = 1'b0;
        p1 = 1'b0;
      end
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; a0 = $urandom_range(0, 7); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; a1 = $urandom_range(0, 7); d1 = $urandom;
      end
      bus.req0_valid = p0; bus.req0_addr = a0[4:0]; bus.req0_data = d0;
      bus.req1_valid = p1; bus.req1_addr = a1[4:0]; bus.req1_data = d1;
      bus.resv_valid = ($urandom_range(0, 3) == 0);
      bus.resv_addr  = 5'($urandom_range(0, 7));
      bus.rd_addr1   = 5'($urandom_range(0, 7));
      bus.rd_addr2   = 5'($urandom_range(0, 7));
      eval();
      if (n_hs0) p0 = 1'b0;
      if (n_hs1) p1 = 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the 32x32 register file, which has two async read ports and one synchronous write port with x0 hard-wired to zero. It shares the single write port between the core writeback path (requester 0) and a multi-cycle unit such as LSU or mul/div (requester 1). It keeps a scoreboard of destination registers reserved by the multi-cycle unit, and flags read hazards for the decode stage. It sits between the writeback sources and the register file's WE3/A3/WD3 inputs.

## Interface
- XLEN, 32, data width
- REG_AW, 5, register address width (32 registers)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req0_valid / req1_valid  in  1  write request from requester 0 / 1
- req0_addr / req1_addr  in  REG_AW  destination register
- req0_data / req1_data  in  XLEN  write data
- req0_ready / req1_ready  out  1  grant; a handshake occurs on valid & ready
- resv_valid  in  1  requester 1 dispatch: reserve resv_addr
- resv_addr  in  REG_AW  register to reserve
- resv_ready  out  1  reservation accepted
- rd_addr1 / rd_addr2  in  REG_AW  decode-stage read addresses
- hazard1 / hazard2  out  1  read of rd_addrN must stall
- rf_we  out  1  to WE3
- rf_addr  out  REG_AW  to A3
- rf_wdata  out  XLEN  to WD3

## Operation
- Arbitration:
  - At most one readyN is high per cycle.
  - readyN is high only if reqN_valid is high and N wins arbitration.
  - Both ready outputs are 0 while rst is high.
- Round-robin:
  - Pointer last_grant is reset to 1, so requester 0 wins the first conflict.
  - On a conflict, the requester that is not last_grant wins.
  - last_grant updates only on a handshake.
- Output register:
  - On a handshake, rf_we <= (addr != 0), rf_addr <= addr, rf_wdata <= data.
  - With no handshake, rf_we <= 0 and rf_addr/rf_wdata hold their values.
- x0: a write to x0 completes the handshake normally and is dropped (rf_we stays 0).
- Scoreboard: 32-bit vector sb; bit 0 is never set.
  - Set: on resv_valid & resv_ready with resv_addr != 0.
  - Clear: on a req1 handshake to req1_addr. Requester 0 writes never clear sb.
  - Same-cycle set and clear of the same address: set wins.
- resv_ready = !sb[resv_addr] | (req1 handshake this cycle to resv_addr) | (resv_addr == 0).
- hazardN = (rd_addrN != 0) & (sb[rd_addrN] | (rf_we & rf_addr == rd_addrN)).
  - The second term covers a write held in the output register that the register file has not yet committed.

## Timing
- Reset values: rf_we = 0, rf_addr = 0, rf_wdata = 0, sb = 0, last_grant = 1.
  - Combinational outputs follow from these: hazard1/2 = 0, resv_ready = 1.
- Reset mid-operation: any in-flight request is dropped unacknowledged. A pending rf_we is cancelled on the reset edge.
- readyN, resv_ready and hazardN are combinational from the same-cycle inputs and state. There are no combinational paths from rf_* inputs.
- Latency: handshake at edge k → rf_we = 1 during cycle k+1 → register file updated at edge k+2. hazard is deasserted from cycle k+2.
- Throughput: one write per cycle sustained.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Requesters must hold valid, addr and data stable until ready.

## Configuration
- RF_ARB_RR_EN defined: round-robin arbitration as above.
- RF_ARB_RR_EN undefined: fixed priority, requester 0 always wins. The last_grant register is not built.

## Structure
- Package rf_arb_pkg holds:
  - XLEN and REG_AW localparams.
  - typedef reg_addr_t = logic [REG_AW-1:0].
  - typedef word_t = logic [XLEN-1:0].
  - enum grant_e {GNT_NONE, GNT_REQ0, GNT_REQ1}.
- Sub-module rf_scoreboard holds the sb vector, the set/clear logic, resv_ready and the hazard lookups. It is instantiated once.

## Test plan
- Reset: hold rst 3 cycles with both requests valid → both ready = 0, rf_we = 0, hazards = 0, resv_ready = 1.
- Single write: req0 writes x5 = 0xDEADBEEF → next cycle rf_we = 1, rf_addr = 5, rf_wdata = 0xDEADBEEF. hazard1 with rd_addr1 = 5 is high that cycle and low the cycle after.
- Contention, RR enabled: both valid for 4 cycles (req0 → x1, req1 → x2) → grants 0,1,0,1.
  - Without RF_ARB_RR_EN, same stimulus → grants 0,0,0,0 and req1_ready is never high.
- Scoreboard: reserve x7 → hazard2 (rd_addr2 = 7) stays high. A second reservation of x7 sees resv_ready = 0. req1 writes x7 = 0x12 → hazard clears two cycles after the handshake. Re-reserving x7 in the handshake cycle → resv_ready = 1 and sb[7] stays set.
- x0: req0 writes x0 = 0xFFFFFFFF → handshake completes, rf_we stays 0. Reserving x0 leaves sb = 0, and hazard with rd_addr = 0 is 0.
- Mid-operation reset: assert rst in the cycle after a handshake → rf_we = 0 at the next edge and sb is cleared.
